ad9226_capture_ctrl: RTL and testbench

//  Sample-clock generator and burst-capture controller for one AD9226 channel. Sits upstream of the
//  16b x 8192w ADC->SPI FIFO: generates the ADC clock from the 256 MHz PLL clock by phase accumulation,

---
 rtl/ad9226_cap_pkg.sv | 34 +++
 rtl/phase_acc_clkgen.sv | 39 +++
 rtl/ad9226_capture_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_ad9226_capture_ctrl.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ad9226_cap_pkg.sv
// ---------------------------------------------------------------------------
// ad9226_cap_pkg
//   Shared definitions for the AD9226 burst-capture slice:
//     - capture FSM state encoding
//     - FIFO word layout: {otr, pad, data}
//     - default widths for the capture controller
//     - pack_fifo_word(): builds one FIFO word from an ADC sample
// ---------------------------------------------------------------------------
package ad9226_cap_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARM     = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } cap_state_t;

  localparam int DEF_DATA_W   = 12;
  localparam int DEF_CNT_W    = 16;
  localparam int DEF_ACC_W    = 32;

  localparam int FIFO_W       = 16;
  localparam int FIFO_OTR_BIT = 15;
  localparam int FIFO_PAD_W   = 3;
  localparam int FIFO_DATA_W  = FIFO_OTR_BIT - FIFO_PAD_W;

  function automatic logic [FIFO_W-1:0] pack_fifo_word(
    input logic                   otr,
    input logic [FIFO_DATA_W-1:0] data
  );
    return {otr, {FIFO_PAD_W{1'b0}}, data};
  endfunction

endpackage

// File: rtl/phase_acc_clkgen.sv
// ---------------------------------------------------------------------------
// phase_acc_clkgen
//   Phase-accumulator clock generator for the ADC sample clock.
//   f_adc = f_clk * freq_word / 2^ACC_W; adc_clk is the registered MSB of
//   the accumulator. freq_word = 0 freezes the accumulator (static clock).
// Ports
//   clk        in   system clock
//   rst        in   synchronous active-high reset
//   freq_word  in   phase increment, sampled every cycle
//   adc_clk    out  registered ADC sample clock
//   strobe     out  high in the first cycle adc_clk is high (0->1 edge)
// ---------------------------------------------------------------------------
module phase_acc_clkgen #(
  parameter int ACC_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [ACC_W-1:0] freq_word,
  output logic             adc_clk,
  output logic             strobe
);

  logic [ACC_W-1:0] acc;

  // stage p0: accumulator; stage p1: clock register and rising-edge strobe
  always_ff @(posedge clk) begin
    if (rst) begin
      acc     <= '0;
      adc_clk <= 1'b0;
      strobe  <= 1'b0;
    end else begin
      acc     <= acc + freq_word;
      adc_clk <= acc[ACC_W-1];
      // strobe lines up with the cycle in which adc_clk first reads high
      strobe  <= ~adc_clk & acc[ACC_W-1];
    end
  end

endmodule

// File: rtl/ad9226_capture_ctrl.sv
// ---------------------------------------------------------------------------
// ad9226_capture_ctrl
//   Sample-clock generator and burst-capture controller for one AD9226
//   channel. Generates adc_clk by phase accumulation, captures sample_num
//   consecutive samples (one per adc_clk rising edge) and writes them to
//   the downstream FIFO as {otr, 3'b000, data[11:0]}.
//
//   Optional feature macro: ADC_TRIG_EN
//     defined   : start -> ARM; capture begins on the first strobe where the
//                 previous sample is below trig_level and the current one is
//                 at or above it (unsigned); that sample is written first.
//     undefined : start -> CAPTURE directly; trig_level is ignored.
//
// Ports
//   clk, rst            256 MHz clock, synchronous active-high reset
//   start / abort       1-cycle command pulses (abort wins)
//   freq_word           phase increment for adc_clk
//   sample_num          samples per burst (latched at start)
//   trig_level          trigger threshold (latched at start)
//   adc_otr, adc_data   ADC out-of-range flag and offset-binary data
//   adc_clk             ADC sample clock
//   fifo_wrreq/data     FIFO write port, fifo_full = FIFO wrfull
//   busy                high while arming or capturing
//   done                1-cycle pulse at normal burst end
//   overflow            sticky: a sample was dropped on full (start clears)
//   sample_cnt          samples actually written this burst
// ---------------------------------------------------------------------------
module ad9226_capture_ctrl
  import ad9226_cap_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int CNT_W  = DEF_CNT_W,
  parameter int ACC_W  = DEF_ACC_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [ACC_W-1:0]  freq_word,
  input  logic [CNT_W-1:0]  sample_num,
  input  logic [DATA_W-1:0] trig_level,
  input  logic              adc_otr,
  input  logic [DATA_W-1:0] adc_data,
  output logic              adc_clk,
  output logic              fifo_wrreq,
  output logic [FIFO_W-1:0] fifo_data,
  input  logic              fifo_full,
  output logic              busy,
  output logic              done,
  output logic              overflow,
  output logic [CNT_W-1:0]  sample_cnt
);

  logic              strobe;
  logic [DATA_W-1:0] in_data_p0;
  logic              in_otr_p0;
  cap_state_t        state;
  logic [CNT_W-1:0]  smp_cnt;
  logic [CNT_W-1:0]  num_lat;
  logic              trig_hit;
  logic              take;
  logic              last_smp;

  phase_acc_clkgen #(
    .ACC_W (ACC_W)
  ) u_clkgen (
    .clk       (clk),
    .rst       (rst),
    .freq_word (freq_word),
    .adc_clk   (adc_clk),
    .strobe    (strobe)
  );

  // stage p0: ADC input register; holds the value settled during the low phase
  always_ff @(posedge clk) begin
    in_data_p0 <= adc_data;
    in_otr_p0  <= adc_otr;
  end

`ifdef ADC_TRIG_EN
  logic [DATA_W-1:0] trig_lat;
  logic [DATA_W-1:0] prev_data;
  logic              prev_vld;

  // first strobe after start only primes prev_data; no crossing can be seen yet
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_vld <= 1'b0;
    end else if (state == ST_IDLE && start) begin
      prev_vld <= 1'b0;
    end else if (state == ST_ARM && strobe) begin
      prev_vld <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (state == ST_IDLE && start) begin
      trig_lat <= trig_level;
    end
    if (state == ST_ARM && strobe) begin
      prev_data <= in_data_p0;
    end
  end

  assign trig_hit = prev_vld && (prev_data < trig_lat) && (in_data_p0 >= trig_lat);
`else
  logic unused_trig;
  assign unused_trig = &{1'b0, trig_level};
  assign trig_hit    = 1'b0;
`endif

  // a strobe consumes one burst slot whether or not the FIFO accepts it
  assign take     = strobe && ((state == ST_CAPTURE) || (state == ST_ARM && trig_hit));
  assign last_smp = (smp_cnt + CNT_W'(1)) == num_lat;

  // stage p1: capture FSM and registered FIFO write port
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      fifo_wrreq <= 1'b0;
      fifo_data  <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      overflow   <= 1'b0;
      sample_cnt <= '0;
      smp_cnt    <= '0;
      num_lat    <= '0;
    end else begin
      fifo_wrreq <= 1'b0;
      done       <= 1'b0;
      if (abort) begin
        state <= ST_IDLE;
        busy  <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (start) begin
              overflow   <= 1'b0;
              sample_cnt <= '0;
              smp_cnt    <= '0;
              num_lat    <= sample_num;
              if (sample_num == '0) begin
                state <= ST_DONE;
                done  <= 1'b1;
              end else begin
                busy  <= 1'b1;
`ifdef ADC_TRIG_EN
                state <= ST_ARM;
`else
                state <= ST_CAPTURE;
`endif
              end
            end
          end
          ST_ARM, ST_CAPTURE: begin
            if (take) begin
              if (!fifo_full) begin
                fifo_wrreq <= 1'b1;
                fifo_data  <= pack_fifo_word(in_otr_p0, FIFO_DATA_W'(in_data_p0));
                sample_cnt <= sample_cnt + CNT_W'(1);
              end else begin
                overflow   <= 1'b1;
              end
              smp_cnt <= smp_cnt + CNT_W'(1);
              if (last_smp) begin
                state <= ST_DONE;
                done  <= 1'b1;
                busy  <= 1'b0;
              end else begin
                state <= ST_CAPTURE;
              end
            end
          end
          ST_DONE: state <= ST_IDLE;
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ad9226_capture_ctrl.sv
module tb_ad9226_capture_ctrl;

  localparam int DATA_W = 12;
  localparam int CNT_W  = 16;
  localparam int ACC_W  = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic              abort;
  logic [ACC_W-1:0]  freq_word;
  logic [CNT_W-1:0]  sample_num;
  logic [DATA_W-1:0] trig_level;
  logic              adc_otr;
  logic [DATA_W-1:0] adc_data;
  logic              adc_clk;
  logic              fifo_wrreq;
  logic [15:0]       fifo_data;
  logic              fifo_full;
  logic              busy;
  logic              done;
  logic              overflow;
  logic [CNT_W-1:0]  sample_cnt;

  ad9226_capture_ctrl #(
    .DATA_W (DATA_W),
    .CNT_W  (CNT_W),
    .ACC_W  (ACC_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .abort      (abort),
    .freq_word  (freq_word),
    .sample_num (sample_num),
    .trig_level (trig_level),
    .adc_otr    (adc_otr),
    .adc_data   (adc_data),
    .adc_clk    (adc_clk),
    .fifo_wrreq (fifo_wrreq),
    .fifo_data  (fifo_data),
    .fifo_full  (fifo_full),
    .busy       (busy),
    .done       (done),
    .overflow   (overflow),
    .sample_cnt (sample_cnt)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [15:0] exp_q[$];
  int          wr_cnt = 0;
  int          done_cnt = 0;
  int          cyc = 0;
  int          last_wr_cyc = 0;
  int          clk_toggles = 0;
  bit          chk_spacing = 1'b0;
  logic [11:0] seq [0:15];
  int          seq_len = 1;
  int          samp_idx = 0;
  bit          data_en = 1'b0;
  bit          full_win = 1'b0;
  bit          fell = 1'b0;
  logic        clk_prev = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // output monitor: every FIFO write is popped against the scoreboard
  always @(negedge clk) begin
    cyc++;
    if (fifo_wrreq) begin
      if (exp_q.size() == 0) chk("extra_wrreq", 32'(fifo_data), 32'h0001_0000);
      else                   chk("fifo_data", 32'(fifo_data), 32'(exp_q.pop_front()));
      if (chk_spacing && wr_cnt > 0) chk("wr_spacing", cyc - last_wr_cyc, 16);
      last_wr_cyc = cyc;
      wr_cnt++;
    end
    if (done) done_cnt++;
  end

  // one clock step; ADC data advances on each adc_clk falling edge
  task automatic tick();
    @(negedge clk);
    #1;
    fell = clk_prev && !adc_clk;
    if (adc_clk != clk_prev) clk_toggles++;
    clk_prev = adc_clk;
    if (data_en && fell) begin
      if (samp_idx < seq_len - 1) samp_idx++;
      adc_data = seq[samp_idx];
    end
    if (full_win) fifo_full = (samp_idx == 1 || samp_idx == 2);
  endtask

  task automatic set_ramp(input logic [11:0] base, input logic [11:0] step);
    for (int i = 0; i < 16; i++) seq[i] = base + 12'(i) * step;
    seq_len = 16;
  endtask

  task automatic align_fall();
    int n;
    n = 0;
    tick();
    while (!fell && n < 64) begin
      tick();
      n++;
    end
    chk("align_fall", 32'(fell), 32'd1);
    samp_idx = 0;
    adc_data = seq[0];
    data_en  = 1'b1;
    if (full_win) fifo_full = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int max_cyc);
    int n;
    n = 0;
    while (!done && n < max_cyc) begin
      tick();
      n++;
    end
    chk("done_seen", 32'(done), 32'd1);
    chk("busy_at_done", 32'(busy), 32'd0);
    tick();
    chk("done_one_cycle", 32'(done), 32'd0);
  endtask

  task automatic wait_writes(input int target, input int max_cyc);
    int n;
    n = 0;
    while (wr_cnt < target && n < max_cyc) begin
      tick();
      n++;
    end
    chk("wr_reached", wr_cnt, target);
  endtask

  initial begin
    rst        = 1'b1;
    start      = 1'b0;
    abort      = 1'b0;
    freq_word  = '0;
    sample_num = '0;
    trig_level = '0;
    adc_otr    = 1'b0;
    adc_data   = '0;
    fifo_full  = 1'b0;
    set_ramp(12'h000, 12'h001);
    repeat (4) tick();

    // reset state
    chk("rst_adc_clk", 32'(adc_clk), 32'd0);
    chk("rst_wrreq", 32'(fifo_wrreq), 32'd0);
    chk("rst_fifo_data", 32'(fifo_data), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_sample_cnt", 32'(sample_cnt), 32'd0);
    rst = 1'b0;

    // 1: 16 MHz, 4-sample ramp burst
    freq_word = 32'h1000_0000;
    set_ramp(12'h100, 12'h001);
    sample_num = 4;
    for (int i = 0; i < 4; i++) exp_q.push_back(16'h0100 + 16'(i));
    wr_cnt = 0; done_cnt = 0; chk_spacing = 1'b1;
    align_fall();
    pulse_start();
    chk("t1_busy", 32'(busy), 32'd1);
    wait_done(200);
    chk("t1_writes", wr_cnt, 4);
    chk("t1_q_empty", exp_q.size(), 0);
    chk("t1_done_cnt", done_cnt, 1);
    chk("t1_sample_cnt", 32'(sample_cnt), 32'd4);
    chk_spacing = 1'b0;

    // 2: sample_num = 0 finishes immediately
    sample_num = 0;
    wr_cnt = 0;
    pulse_start();
    chk("t2_done", 32'(done), 32'd1);
    chk("t2_busy", 32'(busy), 32'd0);
    tick();
    chk("t2_done_clr", 32'(done), 32'd0);
    chk("t2_busy_after", 32'(busy), 32'd0);
    chk("t2_writes", wr_cnt, 0);

    // 3: FIFO full during samples 2-3 of 5
    set_ramp(12'h200, 12'h001);
    sample_num = 5;
    exp_q.push_back(16'h0200);
    exp_q.push_back(16'h0203);
    exp_q.push_back(16'h0204);
    wr_cnt = 0;
    full_win = 1'b1;
    align_fall();
    pulse_start();
    wait_done(300);
    full_win = 1'b0;
    fifo_full = 1'b0;
    chk("t3_writes", wr_cnt, 3);
    chk("t3_overflow", 32'(overflow), 32'd1);
    chk("t3_sample_cnt", 32'(sample_cnt), 32'd3);
    chk("t3_q_empty", exp_q.size(), 0);
    sample_num = 0;
    pulse_start();
    chk("t3_ovf_cleared", 32'(overflow), 32'd0);
    chk("t3_cnt_cleared", 32'(sample_cnt), 32'd0);
    tick();

    // 4: abort after 2nd write of 10; start while busy is ignored
    set_ramp(12'h300, 12'h001);
    sample_num = 10;
    exp_q.push_back(16'h0300);
    exp_q.push_back(16'h0301);
    wr_cnt = 0; done_cnt = 0;
    align_fall();
    pulse_start();
    wait_writes(1, 100);
    sample_num = 1;
    pulse_start();
    chk("t4_busy_kept", 32'(busy), 32'd1);
    chk("t4_cnt_kept", 32'(sample_cnt), 32'd1);
    wait_writes(2, 100);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("t4_busy_abort", 32'(busy), 32'd0);
    repeat (100) tick();
    chk("t4_writes", wr_cnt, 2);
    chk("t4_no_done", done_cnt, 0);
    chk("t4_q_empty", exp_q.size(), 0);

    // 5: out-of-range flag, then frozen clock
    set_ramp(12'hFFF, 12'h000);
    adc_otr = 1'b1;
    sample_num = 1;
    exp_q.push_back(16'h8FFF);
    wr_cnt = 0;
    align_fall();
    pulse_start();
    wait_done(100);
    chk("t5_writes", wr_cnt, 1);
    adc_otr = 1'b0;
    freq_word = '0;
    repeat (4) tick();
    clk_toggles = 0;
    wr_cnt = 0;
    sample_num = 2;
    pulse_start();
    repeat (200) tick();
    chk("t5_clk_static", clk_toggles, 0);
    chk("t5_no_writes", wr_cnt, 0);
    chk("t5_busy_stall", 32'(busy), 32'd1);
    chk("t5_cnt_zero", 32'(sample_cnt), 32'd0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("t5_busy_abort", 32'(busy), 32'd0);

`ifdef ADC_TRIG_EN
    // 6: trigger on rising crossing of 0x800
    freq_word = 32'h1000_0000;
    seq[0] = 12'h900; seq[1] = 12'h7F0; seq[2] = 12'h810; seq[3] = 12'h820;
    seq_len = 4;
    trig_level = 12'h800;
    sample_num = 2;
    exp_q.push_back(16'h0810);
    exp_q.push_back(16'h0820);
    wr_cnt = 0;
    align_fall();
    pulse_start();
    trig_level = 12'hFFF;
    wait_done(300);
    chk("t6_writes", wr_cnt, 2);
    chk("t6_q_empty", exp_q.size(), 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
